// File: rtl/vga_timing_pkg.sv
// 640x480@60 timing constants shared by the sync generator and the image locator.
// Also holds the sync/blank bundle that travels down the alignment delay line.
package vga_timing_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  // Active level of HS/VS; 0 means the pulses are low-going.
  localparam logic VGA_SYNC_POL = 1'b0;

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } sync_t;

  function automatic logic sync_level(input logic active, input logic pol);
    return active ? pol : !pol;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with async reset to a configurable value.
// DEPTH=0 degenerates to a wire so callers need no special case.
module vga_delay_line #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_wire
    assign dout = din;
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
  end else begin : g_shift
    logic [WIDTH-1:0] stage [DEPTH];

    // NOTE: every stage is reset, unlike a RAM, because stale stages would
    // otherwise emit spurious syncs right after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
      end else begin
        stage[0] <= din;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign dout = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_sync_generator.sv
// VGA pixel-timing master: counters, sync decode, latency-matched delay of sync/blank
// and the registered pin stage that masks colour outside the active area.
module vga_sync_generator
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE     = VGA_H_ACTIVE,
  parameter int   H_FP         = VGA_H_FP,
  parameter int   H_SYNC       = VGA_H_SYNC,
  parameter int   H_BP         = VGA_H_BP,
  parameter int   V_ACTIVE     = VGA_V_ACTIVE,
  parameter int   V_FP         = VGA_V_FP,
  parameter int   V_SYNC       = VGA_V_SYNC,
  parameter int   V_BP         = VGA_V_BP,
  parameter int   CNTR_WIDTH_H = 10,
  parameter int   CNTR_WIDTH_V = 10,
  parameter int   R_WIDTH      = 8,
  parameter int   G_WIDTH      = 8,
  parameter int   B_WIDTH      = 8,
  parameter int   PIPE_LAT     = 1,
  parameter logic SYNC_POL     = VGA_SYNC_POL
) (
  input  logic                                 CLOCK,
  input  logic                                 RESET_N,
  input  logic [R_WIDTH+G_WIDTH+B_WIDTH-1:0]   RGB_Bus,
  output logic [CNTR_WIDTH_H-1:0]              CounterX,
  output logic [CNTR_WIDTH_V-1:0]              CounterY,
  output logic                                 inDisplayArea,
  output logic                                 FrameStart,
  output logic [R_WIDTH-1:0]                   VGA_R,
  output logic [G_WIDTH-1:0]                   VGA_G,
  output logic [B_WIDTH-1:0]                   VGA_B,
  output logic                                 VGA_HS,
  output logic                                 VGA_VS,
  output logic                                 VGA_BLANK_N,
  output logic                                 VGA_SYNC_N
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNTR_WIDTH_H-1:0] X_LAST     = CNTR_WIDTH_H'(H_TOTAL - 1);
  localparam logic [CNTR_WIDTH_H-1:0] X_ACT_END  = CNTR_WIDTH_H'(H_ACTIVE);
  localparam logic [CNTR_WIDTH_H-1:0] HS_START   = CNTR_WIDTH_H'(H_ACTIVE + H_FP);
  localparam logic [CNTR_WIDTH_H-1:0] HS_END     = CNTR_WIDTH_H'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNTR_WIDTH_V-1:0] Y_LAST     = CNTR_WIDTH_V'(V_TOTAL - 1);
  localparam logic [CNTR_WIDTH_V-1:0] Y_ACT_END  = CNTR_WIDTH_V'(V_ACTIVE);
  localparam logic [CNTR_WIDTH_V-1:0] VS_START   = CNTR_WIDTH_V'(V_ACTIVE + V_FP);
  localparam logic [CNTR_WIDTH_V-1:0] VS_END     = CNTR_WIDTH_V'(V_ACTIVE + V_FP + V_SYNC);

  localparam sync_t SYNC_IDLE = '{hs: !SYNC_POL, vs: !SYNC_POL, de: 1'b0};

  logic  x_wrap;
  logic  y_wrap;
  sync_t sync0;
  sync_t sync_d;

  assign x_wrap = (CounterX == X_LAST);
  assign y_wrap = (CounterY == Y_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      CounterX   <= '0;
      CounterY   <= '0;
      FrameStart <= 1'b0;
    end else begin
      CounterX <= x_wrap ? '0 : CounterX + 1'b1;
      if (x_wrap) CounterY <= y_wrap ? '0 : CounterY + 1'b1;
      // Marks the cycle the counters read (0,0) after a real wrap; reset's (0,0) does not count.
      FrameStart <= x_wrap && y_wrap;
    end
  end

  assign inDisplayArea = (CounterX < X_ACT_END) && (CounterY < Y_ACT_END);

  // NOTE: a default assignment opens the block so no path can leave a field
  // unassigned and infer a latch.
  always_comb begin
    sync0    = SYNC_IDLE;
    sync0.hs = sync_level((CounterX >= HS_START) && (CounterX < HS_END), SYNC_POL);
    sync0.vs = sync_level((CounterY >= VS_START) && (CounterY < VS_END), SYNC_POL);
    sync0.de = inDisplayArea;
  end

  vga_delay_line #(
    .WIDTH    ($bits(sync_t)),
    .DEPTH    (PIPE_LAT),
    .RESET_VAL(SYNC_IDLE)
  ) u_sync_delay (
    .clk  (CLOCK),
    .rst_n(RESET_N),
    .din  (sync0),
    .dout (sync_d)
  );

  // Colour is muxed to zero before the register so an undriven bus in blanking never reaches the DAC.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      {VGA_R, VGA_G, VGA_B} <= '0;
      VGA_HS                <= !SYNC_POL;
      VGA_VS                <= !SYNC_POL;
      VGA_BLANK_N           <= 1'b0;
    end else begin
      {VGA_R, VGA_G, VGA_B} <= sync_d.de ? RGB_Bus : '0;
      VGA_HS                <= sync_d.hs;
      VGA_VS                <= sync_d.vs;
      VGA_BLANK_N           <= sync_d.de;
    end
  end

  assign VGA_SYNC_N = 1'b0;

endmodule

// File: tb/tb_vga_sync_generator.sv
// Bench for vga_sync_generator: default timing at latencies 0, 1 and 3 plus a
// shrunken-timing instance at latency 2 so whole frames fit in a short run.
module tb_vga_sync_generator;

  typedef struct {
    int ha, hf, hsy, hb, va, vf, vsy, vb, lat;
  } tim_t;

  typedef struct packed {
    logic       valid;
    logic [9:0] x;
    logic [9:0] y;
  } pos_t;

  typedef struct {
    int         k;
    logic [9:0] cx, cy;
    logic       ida, blank, hs;
    logic [7:0] r, g, b;
  } vec_t;

  localparam int NI = 4;
  localparam int HD = 6;

  logic clk = 1'b0;
  logic rst_n;

  logic [23:0] rgb [NI];
  logic [9:0]  cx  [NI];
  logic [9:0]  cy  [NI];
  logic        ida [NI];
  logic        fs  [NI];
  logic [7:0]  r   [NI];
  logic [7:0]  g   [NI];
  logic [7:0]  b   [NI];
  logic        hs  [NI];
  logic        vs  [NI];
  logic        bl  [NI];
  logic        sn  [NI];

  tim_t tim  [NI];
  pos_t hist [NI][HD];
  int   k;
  int   tests = 0;
  int   failed = 0;

  int   sweep_err [NI];
  int   sweep_k   [NI];
  int   hs_low    [3];
  int   sm_fs_cnt, sm_first_fs, sm_vs_low, sm_hs_low;

  vec_t vecs [13];

  always #5 clk = ~clk;

  vga_sync_generator #(.PIPE_LAT(0)) u_l0 (
    .CLOCK(clk), .RESET_N(rst_n), .RGB_Bus(rgb[0]), .CounterX(cx[0]), .CounterY(cy[0]),
    .inDisplayArea(ida[0]), .FrameStart(fs[0]), .VGA_R(r[0]), .VGA_G(g[0]), .VGA_B(b[0]),
    .VGA_HS(hs[0]), .VGA_VS(vs[0]), .VGA_BLANK_N(bl[0]), .VGA_SYNC_N(sn[0]));

  vga_sync_generator #(.PIPE_LAT(1)) u_l1 (
    .CLOCK(clk), .RESET_N(rst_n), .RGB_Bus(rgb[1]), .CounterX(cx[1]), .CounterY(cy[1]),
    .inDisplayArea(ida[1]), .FrameStart(fs[1]), .VGA_R(r[1]), .VGA_G(g[1]), .VGA_B(b[1]),
    .VGA_HS(hs[1]), .VGA_VS(vs[1]), .VGA_BLANK_N(bl[1]), .VGA_SYNC_N(sn[1]));

  vga_sync_generator #(.PIPE_LAT(3)) u_l3 (
    .CLOCK(clk), .RESET_N(rst_n), .RGB_Bus(rgb[2]), .CounterX(cx[2]), .CounterY(cy[2]),
    .inDisplayArea(ida[2]), .FrameStart(fs[2]), .VGA_R(r[2]), .VGA_G(g[2]), .VGA_B(b[2]),
    .VGA_HS(hs[2]), .VGA_VS(vs[2]), .VGA_BLANK_N(bl[2]), .VGA_SYNC_N(sn[2]));

  // 16x10 frame (160 cycles) so frame-level behaviour is observable quickly.
  vga_sync_generator #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .PIPE_LAT(2)
  ) u_sm (
    .CLOCK(clk), .RESET_N(rst_n), .RGB_Bus(rgb[3]), .CounterX(cx[3]), .CounterY(cy[3]),
    .inDisplayArea(ida[3]), .FrameStart(fs[3]), .VGA_R(r[3]), .VGA_G(g[3]), .VGA_B(b[3]),
    .VGA_HS(hs[3]), .VGA_VS(vs[3]), .VGA_BLANK_N(bl[3]), .VGA_SYNC_N(sn[3]));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic int htot(input tim_t t);
    return t.ha + t.hf + t.hsy + t.hb;
  endfunction

  function automatic int vtot(input tim_t t);
    return t.va + t.vf + t.vsy + t.vb;
  endfunction

  function automatic pos_t adv(input pos_t p, input tim_t t);
    pos_t n = p;
    if (int'(p.x) == htot(t) - 1) begin
      n.x = '0;
      n.y = (int'(p.y) == vtot(t) - 1) ? 10'd0 : p.y + 10'd1;
    end else begin
      n.x = p.x + 10'd1;
    end
    return n;
  endfunction

  function automatic logic in_area(input pos_t p, input tim_t t);
    return p.valid && int'(p.x) < t.ha && int'(p.y) < t.va;
  endfunction

  // Image path stand-in: a position-derived colour, X or Z wherever it must be ignored.
  function automatic logic [23:0] pat(input pos_t p, input tim_t t);
    if (!in_area(p, t)) return p.x[0] ? 24'bz : 24'bx;
    return {p.x[7:0], p.y[7:0], 8'hA5};
  endfunction

  // Expected {R,G,B,HS,VS,BLANK_N,FrameStart,CounterX,CounterY,inDisplayArea,SYNC_N}.
  function automatic logic [50:0] expect_all(input int i);
    tim_t t   = tim[i];
    pos_t e   = hist[i][t.lat + 1];
    pos_t c   = hist[i][0];
    pos_t p   = hist[i][1];
    logic de  = in_area(e, t);
    logic hsv = 1'b1;
    logic vsv = 1'b1;
    logic fsv = p.valid && int'(p.x) == htot(t) - 1 && int'(p.y) == vtot(t) - 1;
    if (e.valid) begin
      hsv = !(int'(e.x) >= t.ha + t.hf && int'(e.x) < t.ha + t.hf + t.hsy);
      vsv = !(int'(e.y) >= t.va + t.vf && int'(e.y) < t.va + t.vf + t.vsy);
    end
    return {de ? {e.x[7:0], e.y[7:0], 8'hA5} : 24'h0, hsv, vsv, de, fsv,
            c.x, c.y, in_area(c, t), 1'b0};
  endfunction

  function automatic logic [50:0] actual_all(input int i);
    return {r[i], g[i], b[i], hs[i], vs[i], bl[i], fs[i], cx[i], cy[i], ida[i], sn[i]};
  endfunction

  task automatic drive_rgb();
    for (int i = 0; i < NI; i++) rgb[i] = pat(hist[i][tim[i].lat], tim[i]);
  endtask

  task automatic reset_model();
    for (int i = 0; i < NI; i++) begin
      for (int j = 0; j < HD; j++) hist[i][j] = '0;
      hist[i][0] = '{valid: 1'b1, x: 10'd0, y: 10'd0};
      sweep_err[i] = 0;
      sweep_k[i]   = -1;
    end
    for (int i = 0; i < 3; i++) hs_low[i] = 0;
    sm_fs_cnt = 0; sm_first_fs = -1; sm_vs_low = 0; sm_hs_low = 0;
    k = -1;
    drive_rgb();
  endtask

  // One pixel clock: advance the model on the edge, drive next colour, compare on the falling edge.
  task automatic tick();
    @(posedge clk);
    k++;
    for (int i = 0; i < NI; i++) begin
      for (int j = HD - 1; j > 0; j--) hist[i][j] = hist[i][j-1];
      hist[i][0] = adv(hist[i][0], tim[i]);
    end
    #1;
    drive_rgb();
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      if (actual_all(i) !== expect_all(i)) begin
        if (sweep_err[i] == 0) sweep_k[i] = k;
        sweep_err[i]++;
      end
    end
    if (fs[3]) begin
      if (sm_fs_cnt == 0) sm_first_fs = k;
      sm_fs_cnt++;
    end
    if (k >= 160 && k <= 319 && !vs[3]) sm_vs_low++;
    if (k >= 160 && k <= 175 && !hs[3]) sm_hs_low++;
    if (k <= 799) for (int i = 0; i < 3; i++) if (!hs[i]) hs_low[i]++;
  endtask

  task automatic check_reset(input string tag);
    for (int i = 0; i < NI; i++)
      check($sformatf("%s_inst%0d", tag, i),
            {cx[i], cy[i], ida[i], fs[i], r[i], g[i], b[i], hs[i], vs[i], bl[i]},
            {10'd0, 10'd0, 1'b1, 1'b0, 24'h0, 1'b1, 1'b1, 1'b0});
  endtask

  task automatic check_sweep(input string tag);
    for (int i = 0; i < NI; i++)
      check($sformatf("%s_inst%0d_cycles_bad(first_k=%0d)", tag, i, sweep_k[i]),
            64'(sweep_err[i]), 64'd0);
  endtask

  initial begin
    tim[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 0};
    tim[1] = '{640, 16, 96, 48, 480, 10, 2, 33, 1};
    tim[2] = '{640, 16, 96, 48, 480, 10, 2, 33, 3};
    tim[3] = '{8, 2, 3, 3, 6, 1, 2, 1, 2};

    // Latency-1 instance after edge k: counters read k+1, pins show pixel k-1.
    //          k     cx      cy     ida   blank hs    r      g      b
    vecs[0]  = '{0,    10'd1,   10'd0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00};
    vecs[1]  = '{2,    10'd3,   10'd0, 1'b1, 1'b1, 1'b1, 8'h01, 8'h00, 8'hA5};
    vecs[2]  = '{640,  10'd641, 10'd0, 1'b0, 1'b1, 1'b1, 8'h7F, 8'h00, 8'hA5};
    vecs[3]  = '{641,  10'd642, 10'd0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00};
    vecs[4]  = '{656,  10'd657, 10'd0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00};
    vecs[5]  = '{657,  10'd658, 10'd0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
    vecs[6]  = '{752,  10'd753, 10'd0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
    vecs[7]  = '{753,  10'd754, 10'd0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00};
    vecs[8]  = '{798,  10'd799, 10'd0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00};
    vecs[9]  = '{799,  10'd0,   10'd1, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00};
    vecs[10] = '{801,  10'd2,   10'd1, 1'b1, 1'b1, 1'b1, 8'h00, 8'h01, 8'hA5};
    vecs[11] = '{1001, 10'd202, 10'd1, 1'b1, 1'b1, 1'b1, 8'hC8, 8'h01, 8'hA5};
    vecs[12] = '{1440, 10'd641, 10'd1, 1'b0, 1'b1, 1'b1, 8'h7F, 8'h01, 8'hA5};

    rst_n = 1'b0;
    reset_model();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("reset_hold");
    rst_n = 1'b1;

    for (int v = 0; v < 13; v++) begin
      while (k < vecs[v].k) tick();
      check($sformatf("vec%0d_k%0d", v, vecs[v].k),
            {cx[1], cy[1], ida[1], fs[1], bl[1], hs[1], vs[1], r[1], g[1], b[1]},
            {vecs[v].cx, vecs[v].cy, vecs[v].ida, 1'b0, vecs[v].blank, vecs[v].hs, 1'b1,
             vecs[v].r, vecs[v].g, vecs[v].b});
    end
    while (k < 1999) tick();

    for (int i = 0; i < 3; i++) check($sformatf("hs_low_line0_inst%0d", i), 64'(hs_low[i]), 64'd96);
    check("small_vs_low_per_frame", 64'(sm_vs_low), 64'd32);
    check("small_hs_low_per_line", 64'(sm_hs_low), 64'd3);
    check("small_first_framestart_k", 64'(sm_first_fs), 64'd159);
    check("small_framestart_count", 64'(sm_fs_cnt), 64'd12);
    check_sweep("sweep1");

    // Mid-frame reset between edges: outputs must drop before any clock edge.
    check("pre_reset_cx_nonzero", 64'(cx[1] != 10'd0), 64'd1);
    #2 rst_n = 1'b0;
    #1 check_reset("async_reset");
    @(posedge clk);
    @(negedge clk);
    reset_model();
    rst_n = 1'b1;
    while (k < 399) tick();
    check("restart_first_framestart_k", 64'(sm_first_fs), 64'd159);
    check("restart_framestart_count", 64'(sm_fs_cnt), 64'd2);
    check_sweep("sweep2");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
